// File: rtl/lcd_pixel_gen.sv
// ---------------------------------------------------------------------------
// lcd_pixel_gen
//
// Pixel-colour stage that sits directly behind the LTM sync generator of the
// 800x480 panel. It draws eight vertical colour bars with a solid box that
// bounces off the screen edges. The box moves once per frame, at the frame
// tick, so its position never changes while visible pixels are being drawn.
// Colour and the re-timed DEN/HD/VD leave through the same two register
// stages, so they stay aligned at the panel pins.
//
// Ports:
//   CLK      in   1   pixel clock (NCLK of the sync generator)
//   RST      in   1   synchronous reset, active-high
//   Columna  in  11   horizontal counter from the sync generator
//   Fila     in  10   vertical counter from the sync generator
//   DEN_in   in   1   data enable from the sync generator
//   HD_in    in   1   horizontal sync from the sync generator
//   VD_in    in   1   vertical sync from the sync generator
//   PAUSE    in   1   1 = hold the box position (looked at on frame tick only)
//   R, G, B  out  8   pixel colour
//   DEN      out  1   DEN_in delayed by two clocks
//   HD       out  1   HD_in delayed by two clocks
//   VD       out  1   VD_in delayed by two clocks
//
// Optional build macro:
//   GRID_OVERLAY_EN  when defined, a 64-pixel grid (colour 24'h404040) is
//                    drawn over the bars but underneath the box. When it is
//                    not defined no grid logic exists at all.
// ---------------------------------------------------------------------------
module lcd_pixel_gen #(
    parameter int          H_TOTAL = 1056,
    parameter int          V_TOTAL = 525,
    parameter int          H_BP    = 216,
    parameter int          V_BP    = 35,
    parameter int          H_ACT   = 800,
    parameter int          V_ACT   = 480,
    parameter int          BOX_W   = 64,
    parameter int          BOX_H   = 48,
    parameter int          STEP    = 4,
    parameter logic [23:0] BOX_RGB = 24'hFFFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [10:0] Columna,
    input  logic [9:0]  Fila,
    input  logic        DEN_in,
    input  logic        HD_in,
    input  logic        VD_in,
    input  logic        PAUSE,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        DEN,
    output logic        HD,
    output logic        VD
);

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } state_t;

    // Controller state and box position.
    state_t      state_q;
    logic [10:0] bx_q, bx_d;
    logic [9:0]  by_q, by_d;
    logic        dx_q, dx_d;      // 1 = moving right, 0 = moving left
    logic        dy_q, dy_d;      // 1 = moving down,  0 = moving up

    logic        frameTick;
    logic        moveBox;

    // Stage 1 signals.
    logic [10:0] xPix;
    logic [9:0]  yPix;
    logic [10:0] boxRight;
    logic [10:0] boxBottom;
    logic        inBox;
    logic [2:0]  barIdx;
    logic        inBox_q;
    logic [2:0]  bar_q;
    logic        den1_q, hd1_q, vd1_q;
`ifdef GRID_OVERLAY_EN
    logic        gridHit;
    logic        grid_q;
`endif

    // Stage 2 signals.
    logic [23:0] rgb_d, rgb_q;
    logic        den2_q, hd2_q, vd2_q;

    // Last pixel of the last line: exactly one clock per frame, well inside
    // vertical blanking.
    assign frameTick = (Columna == 11'(H_TOTAL - 1)) && (Fila == 10'(V_TOTAL - 1));

    // The first tick after reset only arms the controller; motion starts on
    // the following ticks.
    assign moveBox = frameTick && (state_q == RUN) && !PAUSE;

    // Next box position. An exact edge hit clamps and reverses in the same
    // tick, and the two axes are independent so a corner reverses both.
    // The sums are one bit wider than the position so they cannot wrap.
    always_comb begin
        bx_d = bx_q;
        by_d = by_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if (moveBox) begin
            if (dx_q) begin
                if (({1'b0, bx_q} + 12'(BOX_W + STEP)) >= 12'(H_ACT)) begin
                    bx_d = 11'(H_ACT - BOX_W);
                    dx_d = 1'b0;
                end else begin
                    bx_d = bx_q + 11'(STEP);
                end
            end else begin
                if (bx_q <= 11'(STEP)) begin
                    bx_d = 11'd0;
                    dx_d = 1'b1;
                end else begin
                    bx_d = bx_q - 11'(STEP);
                end
            end

            if (dy_q) begin
                if (({1'b0, by_q} + 11'(BOX_H + STEP)) >= 11'(V_ACT)) begin
                    by_d = 10'(V_ACT - BOX_H);
                    dy_d = 1'b0;
                end else begin
                    by_d = by_q + 10'(STEP);
                end
            end else begin
                if (by_q <= 10'(STEP)) begin
                    by_d = 10'd0;
                    dy_d = 1'b1;
                end else begin
                    by_d = by_q - 10'(STEP);
                end
            end
        end
    end

    // Controller: leaves WAIT_SYNC on the first frame tick and only goes back
    // there through reset. The box registers live in the same block because
    // they share the frame-tick timing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= WAIT_SYNC;
            bx_q    <= 11'd0;
            by_q    <= 10'd0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
        end else begin
            if (frameTick) begin
                state_q <= RUN;
            end
            bx_q <= bx_d;
            by_q <= by_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    // Active-area coordinates. Outside the active window these wrap to large
    // values, which is harmless because DEN is low there.
    assign xPix      = Columna - 11'(H_BP);
    assign yPix      = Fila - 10'(V_BP);
    assign boxRight  = bx_q + 11'(BOX_W);
    assign boxBottom = {1'b0, by_q} + 11'(BOX_H);

    assign inBox = (xPix >= bx_q) && (xPix < boxRight) &&
                   ({1'b0, yPix} >= {1'b0, by_q}) && ({1'b0, yPix} < boxBottom);

    // Bar index x/100 via a threshold ladder instead of a divider.
    always_comb begin
        if (xPix < 11'd100) begin
            barIdx = 3'd0;
        end else if (xPix < 11'd200) begin
            barIdx = 3'd1;
        end else if (xPix < 11'd300) begin
            barIdx = 3'd2;
        end else if (xPix < 11'd400) begin
            barIdx = 3'd3;
        end else if (xPix < 11'd500) begin
            barIdx = 3'd4;
        end else if (xPix < 11'd600) begin
            barIdx = 3'd5;
        end else if (xPix < 11'd700) begin
            barIdx = 3'd6;
        end else begin
            barIdx = 3'd7;
        end
    end

`ifdef GRID_OVERLAY_EN
    assign gridHit = (xPix[5:0] == 6'd0) || (yPix[5:0] == 6'd0);
`endif

    // Stage 1: register the per-pixel decisions and the first sync delay.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inBox_q <= 1'b0;
            bar_q   <= 3'd0;
            den1_q  <= 1'b0;
            hd1_q   <= 1'b1;
            vd1_q   <= 1'b1;
`ifdef GRID_OVERLAY_EN
            grid_q  <= 1'b0;
`endif
        end else begin
            inBox_q <= inBox;
            bar_q   <= barIdx;
            den1_q  <= DEN_in;
            hd1_q   <= HD_in;
            vd1_q   <= VD_in;
`ifdef GRID_OVERLAY_EN
            grid_q  <= gridHit;
`endif
        end
    end

    // Colour priority: blanking/not running, then box, then grid (optional),
    // then the bar palette.
    always_comb begin
        rgb_d = 24'h000000;
        if ((state_q == RUN) && den1_q) begin
            if (inBox_q) begin
                rgb_d = BOX_RGB;
`ifdef GRID_OVERLAY_EN
            end else if (grid_q) begin
                rgb_d = 24'h404040;
`endif
            end else begin
                case (bar_q)
                    3'd0:    rgb_d = 24'hFFFFFF;
                    3'd1:    rgb_d = 24'hFFFF00;
                    3'd2:    rgb_d = 24'h00FFFF;
                    3'd3:    rgb_d = 24'h00FF00;
                    3'd4:    rgb_d = 24'hFF00FF;
                    3'd5:    rgb_d = 24'hFF0000;
                    3'd6:    rgb_d = 24'h0000FF;
                    default: rgb_d = 24'h000000;
                endcase
            end
        end
    end

    // Stage 2: output registers, so colour and sync leave together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rgb_q  <= 24'h000000;
            den2_q <= 1'b0;
            hd2_q  <= 1'b1;
            vd2_q  <= 1'b1;
        end else begin
            rgb_q  <= rgb_d;
            den2_q <= den1_q;
            hd2_q  <= hd1_q;
            vd2_q  <= vd1_q;
        end
    end

    assign R   = rgb_q[23:16];
    assign G   = rgb_q[15:8];
    assign B   = rgb_q[7:0];
    assign DEN = den2_q;
    assign HD  = hd2_q;
    assign VD  = vd2_q;

endmodule

// File: tb/tb_lcd_pixel_gen.sv
// ---------------------------------------------------------------------------
// tb_lcd_pixel_gen
//
// Directed bench for lcd_pixel_gen. Counter pairs are presented directly,
// and a frame is represented by a single cycle at the last counter pair, so
// hundreds of box moves fit in a few thousand clocks. A behavioural model
// tracks the box and the expected panel outputs; every cycle the DUT is
// compared against it, and hand-computed literals pin selected pixels and
// the model's box position.
// ---------------------------------------------------------------------------
module tb_lcd_pixel_gen;

    logic        CLK     = 1'b0;
    logic        RST     = 1'b1;
    logic [10:0] Columna = 11'd0;
    logic [9:0]  Fila    = 10'd0;
    logic        DEN_in  = 1'b0;
    logic        HD_in   = 1'b1;
    logic        VD_in   = 1'b1;
    logic        PAUSE   = 1'b0;
    logic [7:0]  R, G, B;
    logic        DEN, HD, VD;

    int testsRun    = 0;
    int testsFailed = 0;

    lcd_pixel_gen dut (
        .CLK     (CLK),
        .RST     (RST),
        .Columna (Columna),
        .Fila    (Fila),
        .DEN_in  (DEN_in),
        .HD_in   (HD_in),
        .VD_in   (VD_in),
        .PAUSE   (PAUSE),
        .R       (R),
        .G       (G),
        .B       (B),
        .DEN     (DEN),
        .HD      (HD),
        .VD      (VD)
    );

    always #5 CLK = ~CLK;

    // Model state: box position/direction, running flag, and the expected
    // output of one pixel in flight plus the one currently at the pins.
    typedef struct packed {
        logic        den;
        logic        hd;
        logic        vd;
        logic [23:0] rgb;
    } pix_t;

    int   mbx = 0, mby = 0, mdx = 1, mdy = 1;
    bit   mRun = 0;
    pix_t inFlight;
    pix_t atPins;

    // Colour a pixel must get when drawing is enabled, from screen rules.
    function automatic logic [23:0] pixelColour(input int col, input int row);
        int x, y, bar;
        logic [23:0] pal [8];
        pal[0] = 24'hFFFFFF; pal[1] = 24'hFFFF00; pal[2] = 24'h00FFFF; pal[3] = 24'h00FF00;
        pal[4] = 24'hFF00FF; pal[5] = 24'hFF0000; pal[6] = 24'h0000FF; pal[7] = 24'h000000;
        x = (col - 216) & 2047;
        y = (row - 35) & 1023;
        if (x >= mbx && x < mbx + 64 && y >= mby && y < mby + 48) return 24'hFFFFFF;
`ifdef GRID_OVERLAY_EN
        if ((x % 64) == 0 || (y % 64) == 0) return 24'h404040;
`endif
        bar = x / 100;
        if (bar > 7) bar = 7;
        return pal[bar];
    endfunction

    task automatic modelMove();
        if (mdx > 0) begin
            if (mbx + 64 + 4 >= 800) begin mbx = 736; mdx = -1; end
            else mbx = mbx + 4;
        end else begin
            if (mbx <= 4) begin mbx = 0; mdx = 1; end
            else mbx = mbx - 4;
        end
        if (mdy > 0) begin
            if (mby + 48 + 4 >= 480) begin mby = 432; mdy = -1; end
            else mby = mby + 4;
        end else begin
            if (mby <= 4) begin mby = 0; mdy = 1; end
            else mby = mby - 4;
        end
    endtask

    // Model update on each active edge, then a compare 1 ns later.
    always @(posedge CLK) begin
        if (RST) begin
            atPins   = '{den: 1'b0, hd: 1'b1, vd: 1'b1, rgb: 24'h0};
            inFlight = '{den: 1'b0, hd: 1'b1, vd: 1'b1, rgb: 24'h0};
            mbx = 0; mby = 0; mdx = 1; mdy = 1; mRun = 0;
        end else begin
            atPins.den = inFlight.den;
            atPins.hd  = inFlight.hd;
            atPins.vd  = inFlight.vd;
            atPins.rgb = (mRun && inFlight.den) ? inFlight.rgb : 24'h0;
            inFlight.den = DEN_in;
            inFlight.hd  = HD_in;
            inFlight.vd  = VD_in;
            inFlight.rgb = pixelColour(int'(Columna), int'(Fila));
            if (Columna == 11'd1055 && Fila == 10'd524) begin
                if (!mRun) mRun = 1;
                else if (!PAUSE) modelMove();
            end
        end
        #1;
        testsRun++;
        if ({R, G, B} !== atPins.rgb || DEN !== atPins.den || HD !== atPins.hd || VD !== atPins.vd) begin
            testsFailed++;
            $display("[TB] FAIL cycle_compare @%0t: got rgb=%06h den=%b hd=%b vd=%b, want rgb=%06h den=%b hd=%b vd=%b",
                     $time, {R, G, B}, DEN, HD, VD, atPins.rgb, atPins.den, atPins.hd, atPins.vd);
        end
    end

    task automatic applyStimulus(input int col, input int row, input bit den, input bit hd,
                                 input bit vd, input bit pause, input bit rst);
        Columna = 11'(col);
        Fila    = 10'(row);
        DEN_in  = den;
        HD_in   = hd;
        VD_in   = vd;
        PAUSE   = pause;
        RST     = rst;
        @(negedge CLK);
    endtask

    // Present active pixel (x,y), then an idle cycle so its colour reaches the pins.
    task automatic showPixel(input int x, input int y);
        applyStimulus(216 + x, 35 + y, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0, 0);
    endtask

    task automatic frameTick(input bit pause);
        applyStimulus(1055, 524, 0, 1, 0, pause, 0);
    endtask

    task automatic checkOutput(input string name, input logic [23:0] want);
        testsRun++;
        if ({R, G, B} !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got rgb=%06h, want %06h", name, {R, G, B}, want);
        end
    endtask

    task automatic checkSync(input string name, input bit den, input bit hd, input bit vd);
        testsRun++;
        if (DEN !== den || HD !== hd || VD !== vd) begin
            testsFailed++;
            $display("[TB] FAIL %s: got den/hd/vd=%b%b%b, want %b%b%b", name, DEN, HD, VD, den, hd, vd);
        end
    endtask

    task automatic checkModel(input string name, input int got, input int want);
        testsRun++;
        if (got != want) begin
            testsFailed++;
            $display("[TB] FAIL %s: model has %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        logic [23:0] gridOrWhite;
`ifdef GRID_OVERLAY_EN
        gridOrWhite = 24'h404040;
`else
        gridOrWhite = 24'hFFFFFF;
`endif

        // Reset
        applyStimulus(0, 0, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 1, 0, 1);
        checkOutput("reset_rgb", 24'h000000);
        checkSync("reset_sync", 0, 1, 1);

        // Waiting for sync: sync strobes toggle, colour must stay black
        for (int i = 0; i < 6; i++)
            applyStimulus(210 + i, 35, i >= 3, i != 1, i != 2, 0, 0);
        showPixel(0, 0);
        checkOutput("wait_sync_rgb", 24'h000000);
        checkSync("wait_sync_den", 1, 1, 1);

        // First tick only enables drawing
        frameTick(0);
        showPixel(0, 165);
        checkOutput("bar0_x0", gridOrWhite);
        showPixel(700, 165);
        checkOutput("bar7", 24'h000000);
        showPixel(100, 165);
        checkOutput("bar1", 24'hFFFF00);
        showPixel(300, 165);
        checkOutput("bar3", 24'h00FF00);
        showPixel(500, 165);
        checkOutput("bar5", 24'hFF0000);

        // Second tick moves the box by one step
        frameTick(0);
        checkModel("bx_first_move", mbx, 4);
        checkModel("by_first_move", mby, 4);
        showPixel(4, 4);
        checkOutput("box_corner", 24'hFFFFFF);
        showPixel(3, 4);
        checkOutput("left_of_box", 24'hFFFFFF);

        // 108 moves: Y hits the bottom and reverses
        repeat (107) frameTick(0);
        checkModel("by_bottom", mby, 432);
        checkModel("dy_bottom", mdy, -1);
        checkModel("bx_at_108", mbx, 432);
        showPixel(442, 432);
        checkOutput("box_top_row", 24'hFFFFFF);
        showPixel(442, 431);
        checkOutput("above_box", 24'hFF00FF);
        showPixel(442, 479);
        checkOutput("box_last_line", 24'hFFFFFF);
        showPixel(431, 440);
        checkOutput("left_of_box_bar4", 24'hFF00FF);

        // 184 moves: X hits the right edge and reverses
        repeat (76) frameTick(0);
        checkModel("bx_right", mbx, 736);
        checkModel("dx_right", mdx, -1);
        checkModel("by_at_184", mby, 128);
        showPixel(736, 130);
        checkOutput("box_left_col", 24'hFFFFFF);
        showPixel(735, 130);
        checkOutput("left_of_box_bar7", 24'h000000);
        showPixel(799, 130);
        checkOutput("box_last_col", 24'hFFFFFF);

        frameTick(0);
        checkModel("bx_after_reverse", mbx, 732);
        showPixel(732, 130);
        checkOutput("box_after_reverse", 24'hFFFFFF);
        showPixel(731, 130);
        checkOutput("left_after_reverse", 24'h000000);
        showPixel(732, 123);
        checkOutput("above_after_reverse", 24'h000000);

        // Pause holds the box across three ticks
        repeat (3) frameTick(1);
        checkModel("bx_paused", mbx, 732);
        checkModel("by_paused", mby, 124);
        showPixel(731, 130);
        checkOutput("paused_left", 24'h000000);
        showPixel(732, 124);
        checkOutput("paused_corner", 24'hFFFFFF);

        // Resume
        frameTick(0);
        checkModel("bx_resumed", mbx, 728);
        showPixel(731, 130);
        checkOutput("resumed_inside", 24'hFFFFFF);
        showPixel(727, 130);
        checkOutput("resumed_left", 24'h000000);

        // Reset in the middle of a line
        applyStimulus(616, 135, 1, 0, 1, 0, 0);
        applyStimulus(617, 135, 1, 1, 0, 0, 1);
        checkOutput("midline_reset_rgb", 24'h000000);
        checkSync("midline_reset_sync", 0, 1, 1);
        applyStimulus(618, 135, 1, 1, 1, 0, 0);
        showPixel(10, 10);
        checkOutput("after_reset_wait", 24'h000000);
        checkModel("bx_after_reset", mbx, 0);

        frameTick(0);
        showPixel(10, 10);
        checkOutput("box_home", 24'hFFFFFF);
        showPixel(64, 10);
        checkOutput("grid_x64", gridOrWhite);
        showPixel(70, 10);
        checkOutput("bar0_after_box", 24'hFFFFFF);
        showPixel(150, 10);
        checkOutput("bar1_after_reset", 24'hFFFF00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
